axis_frame_tx: RTL and testbench
================================

Name: axis_frame_tx

Overview:
- Command-driven AXI4-Stream frame transmitter; the source end of the streams our axis register stages carry.
- Accepts a command (start word address, byte length, user tag) and reads a synchronous RAM with 1-cycle read latency.
- Emits the data as one AXI-Stream frame with tkeep on the last beat, tlast, and tuser on the first beat.
- Holds data through backpressure with an internal 2-entry output buffer; throughput is 1 beat/cycle.

Parameters:
- DATA_WIDTH, 64, stream/RAM word width in bits; must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, bytes per beat.
- ADDR_WIDTH, 10, RAM word-address width.
- LEN_WIDTH, 16, command byte-length width.
- USER_WIDTH, 1, tuser / command tag width.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command ready.
- cmd_addr  input  ADDR_WIDTH  start word address.
- cmd_len  input  LEN_WIDTH  frame length in bytes.
- cmd_user  input  USER_WIDTH  tag driven on tuser of the first beat.
- mem_rd_en  output  1  RAM read strobe.
- mem_rd_addr  output  ADDR_WIDTH  RAM read address.
- mem_rd_data  input  DATA_WIDTH  RAM data, valid the cycle after mem_rd_en.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tkeep  output  KEEP_WIDTH  byte enables.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tlast  output  1  last beat of frame.
- m_axis_tuser  output  USER_WIDTH  cmd_user on first beat, 0 otherwise.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (rstn=0 at a clk edge):
  - Outputs: cmd_ready=0, mem_rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, busy=0; tdata/tkeep don't-care.
  - Internal state: FSM to IDLE, buffer occupancy 0, any in-flight read discarded.
  - cmd_ready=1 on the first cycle after release.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid with cmd_len!=0, latch the command, compute beats=ceil(len/KEEP_WIDTH) and last_keep, then go to RUN. cmd_len==0 is consumed with no beats and no reads; the FSM stays in IDLE.
  - RUN: issue reads at addr, addr+1, ... until all beats have been issued, then go to DRAIN.
  - DRAIN: when the last beat handshakes (tvalid & tready & tlast), go to IDLE. cmd_ready stays 0 outside IDLE, so frames never overlap.
- Read issue rule:
  - mem_rd_en=1 only when (buffer_occupancy + inflight − pop_this_cycle) < 2.
  - pop_this_cycle = m_axis_tvalid & m_axis_tready.
  - Returned data is never dropped.
- Address wrap: mem_rd_addr increments modulo 2^ADDR_WIDTH.
- Latency: with the command handshake in cycle T and tready=1, mem_rd_en is high in T+1 and m_axis_tvalid is first high in T+3. After that, 1 beat/cycle while tready=1.
- Backpressure: while tvalid=1 and tready=0, tdata/tkeep/tlast/tuser stay stable and tvalid stays high. A beat arriving when the output register is full goes to the skid entry.
- tkeep: all ones except the last beat, which is {KEEP_WIDTH{1}} >> (KEEP_WIDTH − (len mod KEEP_WIDTH)), or all ones when len mod KEEP_WIDTH == 0.
- Single-beat frame: tlast=1 and tuser=cmd_user on the same beat.
- Width rules: beats counter is LEN_WIDTH bits; len up to 2^LEN_WIDTH−1 bytes must be supported.

Optional Feature:
- Macro: AXIS_FRAME_TX_STATS_EN.
- When defined, adds outputs stat_frames (32-bit) and stat_beats (32-bit):
  - stat_frames increments on each tlast handshake.
  - stat_beats increments on each beat handshake.
  - Both wrap at 2^32 and reset to 0.
  - A zero-length command increments neither.
- When undefined, the ports and logic are absent and the interface is as above.

Test Plan:
- DATA_WIDTH=64, cmd addr=0x010 len=16, tready=1 → reads at 0x010, 0x011; 2 beats, tkeep=0xFF,0xFF; tlast on beat 2; tuser=1 on beat 1 only; first tvalid at T+3.
- len=13, addr=0x020 → 2 beats, tkeep 0xFF then 0x1F; len=5 → 1 beat, tkeep=0x1F, tlast=1, tuser=cmd_user.
- len=0 → no mem_rd_en, no tvalid; cmd_ready high the next cycle; stats unchanged.
- len=100, tready random 50% → 13 beats in address order, no loss or duplication, exactly 13 mem_rd_en pulses, outputs stable while stalled; tready=1 gives 13 consecutive beats.
- addr=0x3FF len=24 (ADDR_WIDTH=10) → reads 0x3FF, 0x000, 0x001.
- rstn=0 for 1 cycle mid-frame with tready=0 → tvalid=0, busy=0 after the edge; cmd_ready=1 next cycle; a following len=8 command yields exactly 1 clean beat.

Source files
------------

// File: rtl/axis_frame_tx_if.sv
// axis_frame_tx_if: AXI4-Stream bundle carrying the transmitter's output frames.
// Ports: none. Signals: tdata, tkeep, tvalid, tlast, tuser (source-driven), tready (sink-driven).
// Modports: master = stream source, slave = stream sink.
interface axis_frame_tx_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_tx.sv
// axis_frame_tx: command-driven AXI4-Stream frame transmitter reading a 1-cycle-latency RAM.
// Ports: clk, rstn (sync, active-low); cmd_valid/cmd_ready/cmd_addr/cmd_len/cmd_user command
// handshake; mem_rd_en/mem_rd_addr/mem_rd_data RAM read port; busy (frame in progress);
// m_axis (axis_frame_tx_if.master) output stream.
// Optional: define AXIS_FRAME_TX_STATS_EN to add stat_frames / stat_beats counters.
module axis_frame_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [USER_WIDTH-1:0] cmd_user,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
`ifdef AXIS_FRAME_TX_STATS_EN
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_beats,
`endif
    axis_frame_tx_if.master       m_axis
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } ent_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  left_q, left_d;
    logic                  first_q, first_d;
    logic [KEEP_WIDTH-1:0] lkeep_q, lkeep_d;
    logic [USER_WIDTH-1:0] tag_q, tag_d;
    logic                  fly_q, fly_d, fly_first_q, fly_first_d, fly_last_q, fly_last_d;
    logic [1:0]            occ_q, occ_d;
    ent_t                  ent_q [2];
    ent_t                  ent_d [2];
    ent_t                  ent_in;
    logic [LEN_WIDTH:0]    len_ext;
    logic [LEN_WIDTH-1:0]  rem;
    logic                  tvalid, pop, rd, cmd_fire;
    always_comb begin
        len_ext     = {1'b0, cmd_len};
        rem         = cmd_len % LEN_WIDTH'(KEEP_WIDTH);
        tvalid      = occ_q != 2'd0;
        pop         = tvalid & m_axis.tready;
        cmd_fire    = cmd_valid & cmd_ready;
        // Occupancy after this cycle's pop plus the read already in flight must leave room for one more.
        rd          = (state_q == RUN) && (3'(occ_q) + 3'(fly_q) - 3'(pop) < 3'd2);
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        first_d     = first_q;
        lkeep_d     = lkeep_q;
        tag_d       = tag_q;
        fly_d       = rd;
        fly_first_d = first_q;
        fly_last_d  = left_q == LEN_WIDTH'(1);
        if (cmd_fire && cmd_len != '0) begin
            state_d = RUN;
            addr_d  = cmd_addr;
            left_d  = LEN_WIDTH'((len_ext + (LEN_WIDTH+1)'(KEEP_WIDTH - 1)) / (LEN_WIDTH+1)'(KEEP_WIDTH));
            lkeep_d = rem == '0 ? '1 : KEEP_WIDTH'({KEEP_WIDTH{1'b1}} >> (LEN_WIDTH'(KEEP_WIDTH) - rem));
            tag_d   = cmd_user;
            first_d = 1'b1;
        end
        if (rd) begin
            addr_d  = addr_q + 1'b1;
            left_d  = left_q - 1'b1;
            first_d = 1'b0;
            if (left_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
        if (state_q == DRAIN && pop && ent_q[0].last) state_d = IDLE;
        ent_in.data = mem_rd_data;
        ent_in.keep = fly_last_q ? lkeep_q : '1;
        ent_in.last = fly_last_q;
        ent_in.user = fly_first_q ? tag_q : '0;
        // Entry 0 is the output register, entry 1 the skid slot; a pop shifts skid forward.
        ent_d[0] = pop ? ent_q[1] : ent_q[0];
        ent_d[1] = ent_q[1];
        if (fly_q) begin
            if (occ_q == 2'(pop)) ent_d[0] = ent_in;
            else ent_d[1] = ent_in;
        end
        occ_d = occ_q + 2'(fly_q) - 2'(pop);
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            occ_q   <= 2'd0;
            fly_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            fly_q   <= fly_d;
        end
    end
    always_ff @(posedge clk) begin
        addr_q      <= addr_d;
        left_q      <= left_d;
        first_q     <= first_d;
        lkeep_q     <= lkeep_d;
        tag_q       <= tag_d;
        fly_first_q <= fly_first_d;
        fly_last_q  <= fly_last_d;
        ent_q       <= ent_d;
    end
    assign cmd_ready     = rstn && state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign mem_rd_en     = rd;
    assign mem_rd_addr   = addr_q;
    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = ent_q[0].data;
    assign m_axis.tkeep  = ent_q[0].keep;
    assign m_axis.tlast  = tvalid & ent_q[0].last;
    assign m_axis.tuser  = tvalid ? ent_q[0].user : '0;
`ifdef AXIS_FRAME_TX_STATS_EN
    logic [31:0] frames_q, frames_d, beats_q, beats_d;
    always_comb begin
        frames_d = frames_q + 32'(pop & ent_q[0].last);
        beats_d  = beats_q + 32'(pop);
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frames_q <= '0;
            beats_q  <= '0;
        end else begin
            frames_q <= frames_d;
            beats_q  <= beats_d;
        end
    end
    assign stat_frames = frames_q;
    assign stat_beats  = beats_q;
`endif
endmodule

// File: tb/tb_axis_frame_tx.sv
// tb_axis_frame_tx: randomized self-checking bench for axis_frame_tx against a byte-level frame model.
module tb_axis_frame_tx;
    localparam int DW = 64, KW = 8, AW = 10, LW = 16, UW = 1;
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;
    logic          clk = 0, rstn = 0, cmd_valid = 0, cmd_user = 0;
    logic          cmd_ready, mem_rd_en, busy;
    logic [AW-1:0] cmd_addr = '0, mem_rd_addr;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] mem [1024];
    axis_frame_tx_if #(.DATA_WIDTH(DW)) ax();
    int n_cmp = 0, n_bad = 0, beat_cnt = 0, rdy_rand = 0;
    logic rdy_fix = 1'b1, stall_q = 1'b0;
    beat_t exp_q[$];
    logic [AW-1:0] exp_rd[$];
    beat_t mon_e, held;
`ifdef AXIS_FRAME_TX_STATS_EN
    logic [31:0] stat_frames, stat_beats;
    int unsigned mdl_frames = 0, mdl_beats = 0;
`endif
    axis_frame_tx dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_user(cmd_user),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .busy(busy),
`ifdef AXIS_FRAME_TX_STATS_EN
        .stat_frames(stat_frames), .stat_beats(stat_beats),
`endif
        .m_axis(ax)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    always @(posedge clk) begin
        #1;
        ax.tready = rdy_rand != 0 ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Expected frame built from byte counts: full beats of KW bytes, the remainder on the last one.
    task automatic model_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic u);
        int left = int'(l);
        int i = 0;
        int k;
        beat_t b;
        while (left > 0) begin
            k = left >= KW ? KW : left;
            b.d = mem[AW'(int'(a) + i)];
            b.k = KW'((1 << k) - 1);
            b.l = left <= KW;
            b.u = i == 0 ? u : 1'b0;
            exp_q.push_back(b);
            exp_rd.push_back(AW'(int'(a) + i));
            left -= KW;
            i++;
        end
`ifdef AXIS_FRAME_TX_STATS_EN
        mdl_frames += (l != 0) ? 1 : 0;
        mdl_beats += i;
`endif
    endtask
    always @(negedge clk) begin
        if (rstn) begin
            if (stall_q) begin
                check("hold_valid", ax.tvalid, 1);
                check("hold_data", ax.tdata, held.d);
                check("hold_keep", ax.tkeep, held.k);
                check("hold_last", ax.tlast, held.l);
                check("hold_user", ax.tuser, held.u);
            end
            if (mem_rd_en) begin
                check("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) check("rd_addr", mem_rd_addr, exp_rd.pop_front());
            end
            if (ax.tvalid && ax.tready) begin
                beat_cnt++;
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("tdata", ax.tdata, mon_e.d);
                    check("tkeep", ax.tkeep, mon_e.k);
                    check("tlast", ax.tlast, mon_e.l);
                    check("tuser", ax.tuser, mon_e.u);
                end
            end
            stall_q = ax.tvalid && !ax.tready;
            held.d = ax.tdata;
            held.k = ax.tkeep;
            held.l = ax.tlast;
            held.u = ax.tuser;
        end else stall_q = 1'b0;
    end
    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic u);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_addr = a;
        cmd_len = l;
        cmd_user = u;
        cmd_valid = 1'b1;
        model_cmd(a, l, u);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask
    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && !busy;
        end
        check("frame_done", done, 1);
        check("reads_left", exp_rd.size(), 0);
`ifdef AXIS_FRAME_TX_STATS_EN
        check("stat_frames", stat_frames, 64'(mdl_frames));
        check("stat_beats", stat_beats, 64'(mdl_beats));
`endif
    endtask
    initial begin
        foreach (mem[i]) mem[i] = {$urandom, $urandom};
        ax.tready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_tvalid", ax.tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_tlast", ax.tlast, 0);
        check("rst_tuser", ax.tuser, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", cmd_ready, 1);
        // Latency: reads in T+1, first tvalid in T+3.
        send_cmd(10'h010, 16'd16, 1'b1);
        @(negedge clk);
        check("lat_rd_en", mem_rd_en, 1);
        check("lat_rd_addr", mem_rd_addr, 10'h010);
        @(negedge clk);
        check("lat_tvalid_t2", ax.tvalid, 0);
        @(negedge clk);
        check("lat_tvalid_t3", ax.tvalid, 1);
        check("lat_tuser_first", ax.tuser, 1);
        wait_idle();
        send_cmd(10'h020, 16'd13, 1'b0);
        wait_idle();
        send_cmd(10'h030, 16'd5, 1'b1);
        wait_idle();
        send_cmd(10'h040, 16'd0, 1'b1);
        @(negedge clk);
        check("zero_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("zero_rd_en", mem_rd_en, 0);
            check("zero_tvalid", ax.tvalid, 0);
            @(negedge clk);
        end
        wait_idle();
        rdy_rand = 1;
        send_cmd(10'h100, 16'd100, 1'b1);
        wait_idle();
        rdy_rand = 0;
        rdy_fix = 1'b1;
        send_cmd(10'h200, 16'd100, 1'b0);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = ax.tvalid;
            end
            check("consec_start", seen, 1);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                check("consec_tvalid", ax.tvalid, 1);
            end
        end
        wait_idle();
        send_cmd(10'h3FF, 16'd24, 1'b1);
        wait_idle();
        for (int n = 0; n < 25; n++) begin
            rdy_rand = int'($urandom_range(0, 1));
            send_cmd(AW'($urandom), LW'($urandom_range(0, 160)), 1'($urandom));
            wait_idle();
        end
        // Reset in the middle of a stalled frame.
        rdy_rand = 0;
        rdy_fix = 1'b0;
        send_cmd(10'h150, 16'd200, 1'b1);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_tvalid", ax.tvalid, 0);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        exp_rd.delete();
`ifdef AXIS_FRAME_TX_STATS_EN
        mdl_frames = 0;
        mdl_beats = 0;
`endif
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        rdy_fix = 1'b1;
        beat_cnt = 0;
        send_cmd(10'h077, 16'd8, 1'b1);
        wait_idle();
        check("post_rst_beats", beat_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
